// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Channel count, select width and delivery-counter width.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
endpackage

// File: rtl/demux_chan_buf.sv
// One output channel: a single-entry data register, its valid flag
// and a wrapping count of words handed to the consumer.
module demux_chan_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_take;

    assign w_take  = r_valid & i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_count = r_count;

    // A load in the same cycle as a take keeps the channel full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_take) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_take) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/demux_stream_1to4.sv
// Routes a valid/ready input stream to one of four buffered outputs.
// Only the select decode and the input-ready logic live here.
module demux_stream_1to4
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [SEL_W-1:0]  select,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  out_data0,
    output logic [WIDTH-1:0]  out_data1,
    output logic [WIDTH-1:0]  out_data2,
    output logic [WIDTH-1:0]  out_data3,
    output logic [CNT_W-1:0]  count0,
    output logic [CNT_W-1:0]  count1,
    output logic [CNT_W-1:0]  count2,
    output logic [CNT_W-1:0]  count3
);

    logic              w_sel_free;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_load;
    logic [WIDTH-1:0]  w_data  [NUM_CH];
    logic [CNT_W-1:0]  w_count [NUM_CH];

    // Selected slot is free if empty or being drained this cycle.
    assign w_sel_free = ~out_valid[select] | out_ready[select];
    assign in_ready   = enable & ~rst & w_sel_free;
    assign w_xfer     = in_valid & in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_load[k] = w_xfer & (select == SEL_W'(k));

        demux_chan_buf #(
            .WIDTH (WIDTH)
        ) u_buf (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_ready (out_ready[k]),
            .o_valid (out_valid[k]),
            .o_data  (w_data[k]),
            .o_count (w_count[k])
        );
    end

    assign out_data0 = w_data[0];
    assign out_data1 = w_data[1];
    assign out_data2 = w_data[2];
    assign out_data3 = w_data[3];
    assign count0    = w_count[0];
    assign count1    = w_count[1];
    assign count2    = w_count[2];
    assign count3    = w_count[3];

endmodule

// File: tb/tb_demux_stream_1to4.sv
// Scoreboard bench for demux_stream_1to4: per-channel expected-word
// queues, directed scenarios, a randomized phase and an async reset.
module tb_demux_stream_1to4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] select;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0] count0, count1, count2, count3;

    logic [7:0] od [4];
    logic [7:0] oc [4];

    logic [7:0] q    [4][$];
    logic [7:0] last [4];
    logic [7:0] mcnt [4];

    int checks = 0;
    int errors = 0;

    demux_stream_1to4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .select    (select),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .count0    (count0),
        .count1    (count1),
        .count2    (count2),
        .count3    (count3)
    );

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;
    assign oc[0] = count0;
    assign oc[1] = count1;
    assign oc[2] = count2;
    assign oc[3] = count3;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last[k] = 8'h00;
            mcnt[k] = 8'h00;
        end
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (rst) begin
            model_reset();
        end else begin
            logic exp_rdy;
            logic [7:0] w;
            exp_rdy = enable &&
                      (q[select].size() == 0 || out_ready[select]);
            chk("in_ready", in_ready, exp_rdy);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid%0d", k), out_valid[k],
                    q[k].size() != 0);
                chk($sformatf("out_data%0d", k), od[k], last[k]);
                chk($sformatf("count%0d", k), oc[k], mcnt[k]);
                if (q[k].size() != 0 && out_ready[k]) begin
                    w = q[k].pop_front();
                    chk($sformatf("deliver%0d", k), od[k], w);
                    mcnt[k] = mcnt[k] + 8'd1;
                end
            end
            if (in_valid && exp_rdy) begin
                q[select].push_back(in_data);
                last[select] = in_data;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 4'h0);
        chk({tag, "_rdy"}, in_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_data%0d", tag, k), od[k], 8'h00);
            chk($sformatf("%s_cnt%0d", tag, k), oc[k], 8'h00);
        end
    endtask

    logic [7:0] route_v [4];

    initial begin
        route_v[0] = 8'h55;
        route_v[1] = 8'hAA;
        route_v[2] = 8'hCC;
        route_v[3] = 8'hF0;
        model_reset();
        rst = 1'b1;
        enable = 1'b1;
        select = 2'd0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 4'h0;
        @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Route
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            select = 2'(i);
            in_valid = 1'b1;
            in_data = route_v[i];
            #4 chk("route_rdy", in_ready, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("route_valid", out_valid, 4'hF);
        for (int k = 0; k < 4; k++)
            chk($sformatf("route_data%0d", k), od[k], route_v[k]);

        // Backpressure on channel 0
        select = 2'd0;
        in_valid = 1'b1;
        in_data = 8'h11;
        #1 chk("bp_rdy0", in_ready, 1'b0);
        chk("bp_hold", out_data0, 8'h55);
        @(negedge clk);
        chk("bp_hold2", out_data0, 8'h55);
        out_ready = 4'b0001;
        #1 chk("bp_rdy1", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 4'h0;
        #1 chk("bp_data", out_data0, 8'h11);
        chk("bp_valid", out_valid[0], 1'b1);
        chk("bp_cnt", count0, 8'd1);

        // Throughput on channel 2 (CC drained first, so 1 + 10)
        @(negedge clk);
        select = 2'd2;
        out_ready = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 8'(i);
            #4 chk("tp_rdy", in_ready, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("tp_cnt", count2, 8'd11);
        chk("tp_data", out_data2, 8'h0A);

        // Enable low: channel 1 still drains
        out_ready = 4'h0;
        enable = 1'b0;
        select = 2'd1;
        in_valid = 1'b1;
        in_data = 8'h77;
        #1 chk("en_rdy", in_ready, 1'b0);
        @(negedge clk);
        out_ready = 4'b0010;
        @(negedge clk);
        out_ready = 4'h0;
        #1 chk("en_valid", out_valid[1], 1'b0);
        chk("en_cnt", count1, 8'd1);
        chk("en_data", out_data1, 8'hAA);

        // Wrap on channel 3: F0 plus 255 streamed words = 256
        @(negedge clk);
        enable = 1'b1;
        select = 2'd3;
        out_ready = 4'b1000;
        for (int i = 0; i < 255; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("wrap_cnt", count3, 8'd0);
        chk("wrap_valid", out_valid[3], 1'b0);

        // Random traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            enable = ($urandom_range(9) != 0);
            select = 2'($urandom);
            in_valid = ($urandom_range(3) != 0);
            in_data = 8'($urandom);
            out_ready = 4'($urandom);
            if (i == 300) begin
                #2 rst = 1'b1;
                #1 check_all_zero("async_rst");
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 4'hF;
        repeat (3) @(negedge clk);
        #1 chk("final_valid", out_valid, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
